// File: rtl/ps2_keydecode_pkg.sv
// Shared scan-code constants, state encodings and small helpers for the
// PS/2 set-2 key decoder.
package ps2_keydecode_pkg;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BRK        = 8'hF0;
   localparam logic [7:0] PS2_PAUSE      = 8'hE1;

   localparam logic [7:0] KEY_LSHIFT     = 8'h12;
   localparam logic [7:0] KEY_RSHIFT     = 8'h59;
   localparam logic [7:0] KEY_CTRL       = 8'h14;
   localparam logic [7:0] KEY_CAPS       = 8'h58;

   localparam logic [7:0] RSP_BAT_OK     = 8'hAA;
   localparam logic [7:0] RSP_ACK        = 8'hFA;
   localparam logic [7:0] RSP_ECHO       = 8'hEE;
   localparam logic [7:0] RSP_RESEND     = 8'hFE;
   localparam logic [7:0] RSP_ERR_LO     = 8'h00;
   localparam logic [7:0] RSP_ERR_HI     = 8'hFF;

   localparam logic [7:0] KEY_UP         = 8'h75;
   localparam logic [7:0] KEY_DOWN       = 8'h72;
   localparam logic [7:0] KEY_RIGHT      = 8'h74;
   localparam logic [7:0] KEY_LEFT       = 8'h6B;
   localparam logic [7:0] KEY_KP_ENTER   = 8'h5A;
   localparam logic [7:0] KEY_KP_SLASH   = 8'h4A;

   localparam logic [7:0] ASCII_ESC      = 8'h1B;
   localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_SLASH    = 8'h2F;

   typedef enum logic [1:0] {
      PFX_IDLE,
      PFX_EXT,
      PFX_BRK,
      PFX_EXT_BRK
   } prefix_t;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_BRACKET,
      SEQ_LETTER
   } seq_t;

   function automatic logic is_ignored(input logic [7:0] c);
      return (c == RSP_BAT_OK) || (c == RSP_ACK) || (c == RSP_ECHO) ||
             (c == RSP_RESEND) || (c == RSP_ERR_LO) || (c == RSP_ERR_HI) ||
             (c == PS2_PAUSE);
   endfunction

   // Characters that have a control equivalent: @ A-Z [ \ ] ^ _ and a-z.
   function automatic logic ctrl_maps(input logic [7:0] c);
      return ((c >= 8'h40) && (c <= 8'h5F)) || ((c >= 8'h61) && (c <= 8'h7A));
   endfunction

endpackage

// File: rtl/ps2_keymap_rom.sv
// Combinational US-layout lookup from non-extended set-2 make codes to ASCII.
// Letters are returned upper case when shift is set; 0 means unmapped.
module ps2_keymap_rom (
   input  logic [7:0] code,
   input  logic       shift,
   output logic [7:0] ascii,
   output logic       is_letter
);

   logic [7:0]  w_upper;
   logic [15:0] w_pair;

   always_comb begin
      w_upper = 8'h00;
      case (code)
         8'h1C: w_upper = 8'h41;
         8'h32: w_upper = 8'h42;
         8'h21: w_upper = 8'h43;
         8'h23: w_upper = 8'h44;
         8'h24: w_upper = 8'h45;
         8'h2B: w_upper = 8'h46;
         8'h34: w_upper = 8'h47;
         8'h33: w_upper = 8'h48;
         8'h43: w_upper = 8'h49;
         8'h3B: w_upper = 8'h4A;
         8'h42: w_upper = 8'h4B;
         8'h4B: w_upper = 8'h4C;
         8'h3A: w_upper = 8'h4D;
         8'h31: w_upper = 8'h4E;
         8'h44: w_upper = 8'h4F;
         8'h4D: w_upper = 8'h50;
         8'h15: w_upper = 8'h51;
         8'h2D: w_upper = 8'h52;
         8'h1B: w_upper = 8'h53;
         8'h2C: w_upper = 8'h54;
         8'h3C: w_upper = 8'h55;
         8'h2A: w_upper = 8'h56;
         8'h1D: w_upper = 8'h57;
         8'h22: w_upper = 8'h58;
         8'h35: w_upper = 8'h59;
         8'h1A: w_upper = 8'h5A;
         default: w_upper = 8'h00;
      endcase
   end

   // {unshifted, shifted} for everything that is not a letter.
   always_comb begin
      w_pair = 16'h0000;
      case (code)
         8'h45: w_pair = {8'h30, 8'h29};
         8'h16: w_pair = {8'h31, 8'h21};
         8'h1E: w_pair = {8'h32, 8'h40};
         8'h26: w_pair = {8'h33, 8'h23};
         8'h25: w_pair = {8'h34, 8'h24};
         8'h2E: w_pair = {8'h35, 8'h25};
         8'h36: w_pair = {8'h36, 8'h5E};
         8'h3D: w_pair = {8'h37, 8'h26};
         8'h3E: w_pair = {8'h38, 8'h2A};
         8'h46: w_pair = {8'h39, 8'h28};
         8'h0E: w_pair = {8'h60, 8'h7E};
         8'h4E: w_pair = {8'h2D, 8'h5F};
         8'h55: w_pair = {8'h3D, 8'h2B};
         8'h54: w_pair = {8'h5B, 8'h7B};
         8'h5B: w_pair = {8'h5D, 8'h7D};
         8'h5D: w_pair = {8'h5C, 8'h7C};
         8'h4C: w_pair = {8'h3B, 8'h3A};
         8'h52: w_pair = {8'h27, 8'h22};
         8'h41: w_pair = {8'h2C, 8'h3C};
         8'h49: w_pair = {8'h2E, 8'h3E};
         8'h4A: w_pair = {8'h2F, 8'h3F};
         8'h29: w_pair = {8'h20, 8'h20};
         8'h5A: w_pair = {8'h0D, 8'h0D};
         8'h66: w_pair = {8'h08, 8'h08};
         8'h0D: w_pair = {8'h09, 8'h09};
         8'h76: w_pair = {8'h1B, 8'h1B};
         default: w_pair = 16'h0000;
      endcase
   end

   always_comb begin
      is_letter = (w_upper != 8'h00);
      if (is_letter)
         ascii = shift ? w_upper : (w_upper | 8'h20);
      else
         ascii = shift ? w_pair[7:0] : w_pair[15:8];
   end

endmodule

// File: rtl/ps2_keydecode.sv
// PS/2 set-2 scan code to ASCII decoder: prefix tracking, modifiers, and
// ANSI escape expansion of the cursor keys into a 1-cycle output strobe.
module ps2_keydecode
   import ps2_keydecode_pkg::*;
#(
   parameter bit ESC_SEQ_EN = 1'b1
) (
   input  logic       clk100,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_complete,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       caps_lock
);

   prefix_t    r_prefix, w_prefix_next;
   seq_t       r_seq, w_seq_next;
   logic [7:0] r_seq_letter, w_seq_letter_next;
   logic       r_lshift, w_lshift_next;
   logic       r_rshift, w_rshift_next;
   logic       r_ctrl, w_ctrl_next;
   logic       r_caps, w_caps_next;
   logic [7:0] r_out_data, w_out_data_next;
   logic       r_out_valid, w_out_valid_next;

   logic [7:0] w_rom_ascii;
   logic       w_rom_letter;
   logic [7:0] w_char;
   logic       w_emit;
   logic [7:0] w_emit_data;
   logic [7:0] w_arrow;

   ps2_keymap_rom u_keymap (
      .code      (in_data),
      .shift     (r_lshift | r_rshift),
      .ascii     (w_rom_ascii),
      .is_letter (w_rom_letter)
   );

   always_comb begin
      w_prefix_next     = r_prefix;
      w_seq_next        = r_seq;
      w_seq_letter_next = r_seq_letter;
      w_lshift_next     = r_lshift;
      w_rshift_next     = r_rshift;
      w_ctrl_next       = r_ctrl;
      w_caps_next       = r_caps;
      w_out_data_next   = r_out_data;
      w_out_valid_next  = 1'b0;
      w_emit            = 1'b0;
      w_emit_data       = 8'h00;
      w_arrow           = 8'h00;

      // Caps Lock flips the case of letters only, equivalent to shift^caps.
      w_char = w_rom_ascii ^ {2'b00, r_caps & w_rom_letter, 5'b00000};
      if (r_ctrl && ctrl_maps(w_char))
         w_char = w_char & 8'h1F;

      if (in_complete) begin
         case (r_prefix)
            PFX_IDLE: begin
               if (in_data == PS2_EXT)
                  w_prefix_next = PFX_EXT;
               else if (in_data == PS2_BRK)
                  w_prefix_next = PFX_BRK;
               else if (!is_ignored(in_data)) begin
                  case (in_data)
                     KEY_LSHIFT: w_lshift_next = 1'b1;
                     KEY_RSHIFT: w_rshift_next = 1'b1;
                     KEY_CTRL:   w_ctrl_next   = 1'b1;
                     KEY_CAPS:   w_caps_next   = ~r_caps;
                     default: begin
                        w_emit      = (w_char != 8'h00);
                        w_emit_data = w_char;
                     end
                  endcase
               end
            end
            PFX_EXT: begin
               if (in_data == PS2_BRK)
                  w_prefix_next = PFX_EXT_BRK;
               else begin
                  w_prefix_next = PFX_IDLE;
                  case (in_data)
                     KEY_CTRL:     w_ctrl_next = 1'b1;
                     KEY_UP:       w_arrow     = 8'h41;
                     KEY_DOWN:     w_arrow     = 8'h42;
                     KEY_RIGHT:    w_arrow     = 8'h43;
                     KEY_LEFT:     w_arrow     = 8'h44;
                     KEY_KP_ENTER: begin
                        w_emit      = 1'b1;
                        w_emit_data = ASCII_CR;
                     end
                     KEY_KP_SLASH: begin
                        w_emit      = 1'b1;
                        w_emit_data = ASCII_SLASH;
                     end
                     default: ;
                  endcase
               end
            end
            PFX_BRK: begin
               w_prefix_next = PFX_IDLE;
               case (in_data)
                  KEY_LSHIFT: w_lshift_next = 1'b0;
                  KEY_RSHIFT: w_rshift_next = 1'b0;
                  KEY_CTRL:   w_ctrl_next   = 1'b0;
                  default: ;
               endcase
            end
            PFX_EXT_BRK: begin
               w_prefix_next = PFX_IDLE;
               if (in_data == KEY_CTRL)
                  w_ctrl_next = 1'b0;
            end
            default: w_prefix_next = PFX_IDLE;
         endcase
      end

      // Output from a new byte is dropped while a strobe is already showing,
      // which also covers the whole escape sequence.
      case (r_seq)
         SEQ_BRACKET: begin
            w_out_valid_next = 1'b1;
            w_out_data_next  = ASCII_LBRACKET;
            w_seq_next       = SEQ_LETTER;
         end
         SEQ_LETTER: begin
            w_out_valid_next = 1'b1;
            w_out_data_next  = r_seq_letter;
            w_seq_next       = SEQ_IDLE;
         end
         default: begin
            if (!r_out_valid) begin
               if (ESC_SEQ_EN && (w_arrow != 8'h00)) begin
                  w_out_valid_next  = 1'b1;
                  w_out_data_next   = ASCII_ESC;
                  w_seq_letter_next = w_arrow;
                  w_seq_next        = SEQ_BRACKET;
               end else if (w_emit) begin
                  w_out_valid_next = 1'b1;
                  w_out_data_next  = w_emit_data;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk100) begin
      if (rst) begin
         r_prefix     <= PFX_IDLE;
         r_seq        <= SEQ_IDLE;
         r_seq_letter <= 8'h00;
         r_lshift     <= 1'b0;
         r_rshift     <= 1'b0;
         r_ctrl       <= 1'b0;
         r_caps       <= 1'b0;
         r_out_data   <= 8'h00;
         r_out_valid  <= 1'b0;
      end else begin
         r_prefix     <= w_prefix_next;
         r_seq        <= w_seq_next;
         r_seq_letter <= w_seq_letter_next;
         r_lshift     <= w_lshift_next;
         r_rshift     <= w_rshift_next;
         r_ctrl       <= w_ctrl_next;
         r_caps       <= w_caps_next;
         r_out_data   <= w_out_data_next;
         r_out_valid  <= w_out_valid_next;
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign caps_lock = r_caps;

endmodule

// File: tb/tb_ps2_keydecode.sv
// Directed bench for ps2_keydecode: feeds scan-code strings and compares the
// captured output strobes against hand-computed ASCII.
module tb_ps2_keydecode;

   logic       clk100 = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_complete = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       caps_lock;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;
   int last_tx = 0;
   int t0;

   logic [7:0] q_data[$];
   int         q_cyc[$];

   ps2_keydecode #(.ESC_SEQ_EN(1'b1)) dut (
      .clk100      (clk100),
      .rst         (rst),
      .in_data     (in_data),
      .in_complete (in_complete),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .caps_lock   (caps_lock)
   );

   always #5 clk100 = ~clk100;

   always @(posedge clk100) cyc <= cyc + 1;

   always @(negedge clk100) begin
      if (out_valid) begin
         q_data.push_back(out_data);
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   function automatic logic [31:0] data_at(input int i);
      return (i < q_data.size()) ? {24'h0, q_data[i]} : 32'hDEAD;
   endfunction

   function automatic int lat_at(input int i);
      return (i < q_cyc.size()) ? (q_cyc[i] - t0) : -1;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk100);
         #1;
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      in_data     = b;
      in_complete = 1'b1;
      last_tx     = cyc;
      @(posedge clk100);
      #1;
      in_complete = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      strobe(b);
      idle(4);
   endtask

   task automatic clear_q();
      q_data.delete();
      q_cyc.delete();
   endtask

   task automatic check_outs(input string tag, input int n,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
      logic [7:0] exp [3];
      exp[0] = e0;
      exp[1] = e1;
      exp[2] = e2;
      check({tag, " count"}, q_data.size(), n);
      for (int i = 0; i < n; i++)
         check($sformatf("%s byte%0d", tag, i), data_at(i), {24'h0, exp[i]});
      clear_q();
   endtask

   initial begin
      idle(3);
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset caps_lock", caps_lock, 0);
      rst = 1'b0;
      idle(2);
      clear_q();

      // Make then break of A, with one-cycle latency
      strobe(8'h1C);
      t0 = last_tx;
      idle(4);
      send(8'hF0); send(8'h1C);
      check("a latency", lat_at(0), 1);
      check_outs("make_break_a", 1, 8'h61, 8'h00, 8'h00);

      send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
      check_outs("shift_a", 1, 8'h41, 8'h00, 8'h00);

      send(8'h58); send(8'hF0); send(8'h58);
      check("caps on", caps_lock, 1);
      send(8'h1C);
      check_outs("caps_a", 1, 8'h41, 8'h00, 8'h00);

      send(8'h12); send(8'h1C);
      check_outs("caps_shift_a", 1, 8'h61, 8'h00, 8'h00);
      send(8'h16); send(8'hF0); send(8'h12);
      check_outs("shift_1", 1, 8'h21, 8'h00, 8'h00);

      send(8'h58); send(8'hF0); send(8'h58);
      check("caps off", caps_lock, 0);
      check_outs("caps_toggle_silent", 0, 8'h00, 8'h00, 8'h00);

      send(8'h14); send(8'h21); send(8'hF0); send(8'h14);
      check_outs("ctrl_c", 1, 8'h03, 8'h00, 8'h00);
      send(8'hE0); send(8'h14); send(8'h1C);
      send(8'hE0); send(8'hF0); send(8'h14); send(8'h1C);
      check_outs("rctrl_a", 2, 8'h01, 8'h61, 8'h00);

      // Up arrow escape sequence timing
      send(8'hE0);
      strobe(8'h75);
      t0 = last_tx;
      idle(5);
      check("esc lat0", lat_at(0), 1);
      check("esc lat1", lat_at(1), 2);
      check("esc lat2", lat_at(2), 3);
      check_outs("up_arrow", 3, 8'h1B, 8'h5B, 8'h41);
      send(8'hE0); send(8'hF0); send(8'h75);
      check_outs("up_break", 0, 8'h00, 8'h00, 8'h00);

      send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
      check_outs("kp_enter", 1, 8'h0D, 8'h00, 8'h00);

      // Shift make during sequence still registers
      send(8'hE0);
      strobe(8'h75);
      strobe(8'h12);
      idle(5);
      check_outs("arrow_then_shift", 3, 8'h1B, 8'h5B, 8'h41);
      send(8'h1C);
      check_outs("shift_held_a", 1, 8'h41, 8'h00, 8'h00);
      send(8'hF0); send(8'h12);

      send(8'hE0); send(8'h74);
      check_outs("right_arrow", 3, 8'h1B, 8'h5B, 8'h43);

      send(8'hE0);
      strobe(8'h72);
      idle(1);
      strobe(8'h1C);
      idle(5);
      check_outs("arrow_drop_a", 3, 8'h1B, 8'h5B, 8'h42);

      // Reset between ESC and '['
      send(8'h58); send(8'hF0); send(8'h58);
      check("caps on again", caps_lock, 1);
      clear_q();
      send(8'hE0);
      strobe(8'h75);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(5);
      check_outs("reset_mid_seq", 1, 8'h1B, 8'h00, 8'h00);
      check("caps after reset", caps_lock, 0);

      send(8'hF0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(1);
      send(8'h1C);
      check_outs("reset_clears_brk", 1, 8'h61, 8'h00, 8'h00);

      send(8'hAA); send(8'hFA);
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h1C);
      check_outs("ignored_pause", 1, 8'h61, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
